// File: rtl/md_issue_stage_if.sv
// Interface for the D/E issue stage of the HI/LO multiply-divide path.
// The pipeline side (master) drives the decoded D-stage instruction, its
// forwarded operands and the hazard/busy inputs. The issue stage (slave)
// returns the E-stage register contents, the start strobe, the D-stage
// stall request and the stall-cycle counter.
interface md_issue_stage_if #(
   parameter int CNT_W = 16
);

   // D-stage side: instruction, operands and the hazard inputs.
   logic             d_valid;
   logic [31:0]      d_ir;
   logic [31:0]      d_rs_val;
   logic [31:0]      d_rt_val;
   logic             hz_stall_other;
   logic             md_busy;

   // E-stage side: register contents handed to the multiply/divide unit.
   logic [31:0]      e_ir;
   logic [31:0]      e_srca;
   logic [31:0]      e_srcb;
   logic             e_valid;
   logic             md_start;

   // Pipeline control and the stall-cycle counter.
   logic             d_stall;
   logic [CNT_W-1:0] md_stall_cnt;

   // Pipeline / environment view.
   modport master (
      output d_valid,
      output d_ir,
      output d_rs_val,
      output d_rt_val,
      output hz_stall_other,
      output md_busy,
      input  e_ir,
      input  e_srca,
      input  e_srcb,
      input  e_valid,
      input  md_start,
      input  d_stall,
      input  md_stall_cnt
   );

   // Issue-stage view.
   modport slave (
      input  d_valid,
      input  d_ir,
      input  d_rs_val,
      input  d_rt_val,
      input  hz_stall_other,
      input  md_busy,
      output e_ir,
      output e_srca,
      output e_srcb,
      output e_valid,
      output md_start,
      output d_stall,
      output md_stall_cnt
   );

endinterface

// File: rtl/md_issue_stage.sv
// D/E pipeline register and issue controller for the HI/LO multiply-divide
// path. Latches the D-stage instruction and forwarded operands into E,
// produces the one-cycle start strobe for mult/multu/div/divu, holds any
// HI/LO instruction in D while a computation is still pending, and counts
// the cycles spent in that hazard with a saturating counter.
module md_issue_stage #(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   md_issue_stage_if.slave   bus
);

   // SPECIAL opcode and the HI/LO related funct codes.
   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] FN_MFHI    = 6'h10;
   localparam logic [5:0] FN_MTHI    = 6'h11;
   localparam logic [5:0] FN_MFLO    = 6'h12;
   localparam logic [5:0] FN_MTLO    = 6'h13;
   localparam logic [5:0] FN_MULT    = 6'h18;
   localparam logic [5:0] FN_MULTU   = 6'h19;
   localparam logic [5:0] FN_DIV     = 6'h1A;
   localparam logic [5:0] FN_DIVU    = 6'h1B;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Decoded D-stage fields.
   logic [5:0]       d_op;
   logic [5:0]       d_fn;
   logic             d_is_start;
   logic             d_is_md;

   // Hazard terms.
   logic             d_md;
   logic             md_pending;
   logic             md_hazard;
   logic             stall;

   // E-stage register state.
   logic [31:0]      ir_q;
   logic [31:0]      srca_q;
   logic [31:0]      srcb_q;
   logic             valid_q;
   logic             start_q;

   // Saturating stall-cycle counter.
   logic [CNT_W-1:0] cnt_q;

   assign d_op = bus.d_ir[31:26];
   assign d_fn = bus.d_ir[5:0];

   // Classify the D-stage instruction: start class kicks off a computation,
   // MD class is anything that touches HI/LO (start class included).
   always_comb begin
      d_is_start = 1'b0;
      d_is_md    = 1'b0;
      if (d_op == OP_SPECIAL) begin
         unique case (d_fn)
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
               d_is_start = 1'b1;
               d_is_md    = 1'b1;
            end
            FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO: begin
               d_is_md    = 1'b1;
            end
            default: begin
               d_is_start = 1'b0;
               d_is_md    = 1'b0;
            end
         endcase
      end
   end

   // HI/LO hazard: a computation is pending either because the unit reports
   // Busy or because the start strobe is out this cycle and Busy has not yet
   // risen. Any real HI/LO instruction in D must wait for it.
   always_comb begin
      d_md       = bus.d_valid & d_is_md;
      md_pending = bus.md_busy | start_q;
      md_hazard  = d_md & md_pending;
      stall      = bus.hz_stall_other | md_hazard;
   end

   // E-stage register: a stall or an empty D stage inserts a bubble,
   // otherwise the D-stage instruction and its operands move into E and the
   // start strobe fires for one cycle if it is a mult/multu/div/divu.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ir_q    <= 32'h0;
         srca_q  <= 32'h0;
         srcb_q  <= 32'h0;
         valid_q <= 1'b0;
         start_q <= 1'b0;
      end else if (stall || !bus.d_valid) begin
         ir_q    <= 32'h0;
         srca_q  <= 32'h0;
         srcb_q  <= 32'h0;
         valid_q <= 1'b0;
         start_q <= 1'b0;
      end else begin
         ir_q    <= bus.d_ir;
         srca_q  <= bus.d_rs_val;
         srcb_q  <= bus.d_rt_val;
         valid_q <= 1'b1;
         start_q <= d_is_start;
      end
   end

   // Count cycles lost to the HI/LO hazard, sticking at all-ones instead of
   // wrapping so a long run never reads back as a small number.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (md_hazard && (cnt_q != CNT_MAX)) begin
         cnt_q <= cnt_q + CNT_ONE;
      end
   end

   assign bus.e_ir         = ir_q;
   assign bus.e_srca       = srca_q;
   assign bus.e_srcb       = srcb_q;
   assign bus.e_valid      = valid_q;
   assign bus.md_start     = start_q;
   assign bus.d_stall      = stall;
   assign bus.md_stall_cnt = cnt_q;

endmodule

// File: tb/tb_md_issue_stage.sv
// Scoreboard bench for md_issue_stage. Each stimulus step drives one cycle
// of D-stage inputs shortly after the rising edge and queues the outputs
// expected during that same cycle; an independent monitor pops and compares
// them on the falling edge.
module tb_md_issue_stage;

   localparam int CNT_W = 16;

   localparam logic [31:0] MULT = 32'h00850018;
   localparam logic [31:0] DIVU = 32'h0085001B;
   localparam logic [31:0] MFHI = 32'h00001010;
   localparam logic [31:0] MFLO = 32'h00001012;
   localparam logic [31:0] MTHI = 32'h00800011;
   localparam logic [31:0] ADDU = 32'h00851021;

   typedef struct {
      int          tag;
      logic [31:0] ir;
      logic [31:0] srca;
      logic [31:0] srcb;
      logic        valid;
      logic        start;
      logic        stall;
      logic [15:0] cnt;
   } exp_t;

   logic clk;
   logic reset;

   exp_t exp_q[$];
   int   compared;
   int   mismatched;
   int   step;

   md_issue_stage_if #(.CNT_W(CNT_W)) bus ();

   md_issue_stage #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against its required value.
   task automatic checkOutput(input string name, input int tag,
                              input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("[TB] FAIL step %0d %s: got %h required %h", tag, name, act, req);
      end
   endtask

   // Drive one cycle of inputs (and reset) just after the rising edge and
   // queue the outputs expected for that cycle.
   task automatic applyStimulus(input logic rst, input logic v, input logic [31:0] ir,
                                input logic [31:0] rs, input logic [31:0] rt,
                                input logic oth, input logic busy,
                                input logic [31:0] x_ir, input logic [31:0] x_a,
                                input logic [31:0] x_b, input logic x_v,
                                input logic x_s, input logic x_st,
                                input logic [15:0] x_cnt);
      exp_t e;
      @(posedge clk);
      #1;
      reset              = rst;
      bus.d_valid        = v;
      bus.d_ir           = ir;
      bus.d_rs_val       = rs;
      bus.d_rt_val       = rt;
      bus.hz_stall_other = oth;
      bus.md_busy        = busy;
      step++;
      e.tag   = step;
      e.ir    = x_ir;
      e.srca  = x_a;
      e.srcb  = x_b;
      e.valid = x_v;
      e.start = x_s;
      e.stall = x_st;
      e.cnt   = x_cnt;
      exp_q.push_back(e);
   endtask

   // Drive one cycle of inputs without queueing an expectation.
   task automatic driveOnly(input logic v, input logic [31:0] ir,
                            input logic oth, input logic busy);
      @(posedge clk);
      #1;
      bus.d_valid        = v;
      bus.d_ir           = ir;
      bus.d_rs_val       = 32'h0;
      bus.d_rt_val       = 32'h0;
      bus.hz_stall_other = oth;
      bus.md_busy        = busy;
   endtask

   // Monitor: on each falling edge, check the outputs against the oldest
   // queued expectation, if any.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checkOutput("e_ir",         e.tag, bus.e_ir,                 e.ir);
         checkOutput("e_srca",       e.tag, bus.e_srca,               e.srca);
         checkOutput("e_srcb",       e.tag, bus.e_srcb,               e.srcb);
         checkOutput("e_valid",      e.tag, {31'h0, bus.e_valid},     {31'h0, e.valid});
         checkOutput("md_start",     e.tag, {31'h0, bus.md_start},    {31'h0, e.start});
         checkOutput("d_stall",      e.tag, {31'h0, bus.d_stall},     {31'h0, e.stall});
         checkOutput("md_stall_cnt", e.tag, {16'h0, bus.md_stall_cnt}, {16'h0, e.cnt});
      end
   end

   // Watchdog so the run always ends on its own.
   initial begin
      #5_000_000;
      mismatched++;
      $display("[TB] FAIL watchdog: got timeout required finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus with hand-computed expectations.
   initial begin
      compared           = 0;
      mismatched         = 0;
      step               = 0;
      reset              = 1'b0;
      bus.d_valid        = 1'b0;
      bus.d_ir           = 32'h0;
      bus.d_rs_val       = 32'h0;
      bus.d_rt_val       = 32'h0;
      bus.hz_stall_other = 1'b0;
      bus.md_busy        = 1'b0;
      repeat (2) @(posedge clk);

      // Reset release with idle inputs: everything zero.
      applyStimulus(1, 0, 32'h0, 32'h0, 32'h0, 0, 0,  32'h0, 32'h0, 32'h0, 0, 0, 0, 16'd0);

      // mult rs=7 rt=-3 issued, E shows it next cycle with a one-cycle strobe.
      applyStimulus(1, 1, MULT, 32'd7, 32'hFFFFFFFD, 0, 0,  32'h0, 32'h0, 32'h0, 0, 0, 0, 16'd0);
      applyStimulus(1, 0, 32'h0, 32'h0, 32'h0, 0, 0,  MULT, 32'd7, 32'hFFFFFFFD, 1, 1, 0, 16'd0);
      applyStimulus(1, 0, 32'h0, 32'h0, 32'h0, 0, 0,  32'h0, 32'h0, 32'h0, 0, 0, 0, 16'd0);

      // mult in E, then reset dropped between edges: E clears without a clock.
      applyStimulus(1, 1, MULT, 32'd1, 32'd2, 0, 0,  32'h0, 32'h0, 32'h0, 0, 0, 0, 16'd0);
      applyStimulus(0, 0, 32'h0, 32'h0, 32'h0, 0, 0,  32'h0, 32'h0, 32'h0, 0, 0, 0, 16'd0);
      applyStimulus(1, 0, 32'h0, 32'h0, 32'h0, 0, 0,  32'h0, 32'h0, 32'h0, 0, 0, 0, 16'd0);

      // mult then mfhi: stalled by the strobe (cycle 0) and Busy (cycles 1-5).
      applyStimulus(1, 1, MULT, 32'd3, 32'd4, 0, 0,  32'h0, 32'h0, 32'h0, 0, 0, 0, 16'd0);
      applyStimulus(1, 1, MFHI, 32'h11, 32'h22, 0, 0,  MULT, 32'd3, 32'd4, 1, 1, 1, 16'd0);
      applyStimulus(1, 1, MFHI, 32'h11, 32'h22, 0, 1,  32'h0, 32'h0, 32'h0, 0, 0, 1, 16'd1);
      applyStimulus(1, 1, MFHI, 32'h11, 32'h22, 0, 1,  32'h0, 32'h0, 32'h0, 0, 0, 1, 16'd2);
      applyStimulus(1, 1, MFHI, 32'h11, 32'h22, 0, 1,  32'h0, 32'h0, 32'h0, 0, 0, 1, 16'd3);
      applyStimulus(1, 1, MFHI, 32'h11, 32'h22, 0, 1,  32'h0, 32'h0, 32'h0, 0, 0, 1, 16'd4);
      applyStimulus(1, 1, MFHI, 32'h11, 32'h22, 0, 1,  32'h0, 32'h0, 32'h0, 0, 0, 1, 16'd5);
      applyStimulus(1, 1, MFHI, 32'h11, 32'h22, 0, 0,  32'h0, 32'h0, 32'h0, 0, 0, 0, 16'd6);
      applyStimulus(1, 0, 32'h0, 32'h0, 32'h0, 0, 0,  MFHI, 32'h11, 32'h22, 1, 0, 0, 16'd6);

      // addu behind a busy mult is never held.
      applyStimulus(1, 1, MULT, 32'd5, 32'd6, 0, 0,  32'h0, 32'h0, 32'h0, 0, 0, 0, 16'd6);
      applyStimulus(1, 1, ADDU, 32'hA, 32'hB, 0, 1,  MULT, 32'd5, 32'd6, 1, 1, 0, 16'd6);
      applyStimulus(1, 0, 32'h0, 32'h0, 32'h0, 0, 1,  ADDU, 32'hA, 32'hB, 1, 0, 0, 16'd6);
      applyStimulus(1, 0, 32'h0, 32'h0, 32'h0, 0, 0,  32'h0, 32'h0, 32'h0, 0, 0, 0, 16'd6);

      // General hazard stall on a non-MD instruction: two bubbles, no count.
      applyStimulus(1, 1, ADDU, 32'd1, 32'd2, 1, 0,  32'h0, 32'h0, 32'h0, 0, 0, 1, 16'd6);
      applyStimulus(1, 1, ADDU, 32'd1, 32'd2, 1, 0,  32'h0, 32'h0, 32'h0, 0, 0, 1, 16'd6);
      applyStimulus(1, 1, ADDU, 32'd1, 32'd2, 0, 0,  32'h0, 32'h0, 32'h0, 0, 0, 0, 16'd6);
      applyStimulus(1, 0, 32'h0, 32'h0, 32'h0, 0, 0,  ADDU, 32'd1, 32'd2, 1, 0, 0, 16'd6);

      // Both stall sources together: one stall, counter still increments.
      applyStimulus(1, 1, MFLO, 32'h0, 32'h0, 1, 1,  32'h0, 32'h0, 32'h0, 0, 0, 1, 16'd6);
      applyStimulus(1, 0, 32'h0, 32'h0, 32'h0, 0, 0,  32'h0, 32'h0, 32'h0, 0, 0, 0, 16'd7);

      // Invalid D slot holding an MD word while busy: no stall, no count.
      applyStimulus(1, 0, MFHI, 32'h0, 32'h0, 0, 1,  32'h0, 32'h0, 32'h0, 0, 0, 0, 16'd7);
      applyStimulus(1, 0, 32'h0, 32'h0, 32'h0, 0, 0,  32'h0, 32'h0, 32'h0, 0, 0, 0, 16'd7);

      // mthi moves to E without a strobe; divu moves with one.
      applyStimulus(1, 1, MTHI, 32'd9, 32'd8, 0, 0,  32'h0, 32'h0, 32'h0, 0, 0, 0, 16'd7);
      applyStimulus(1, 0, 32'h0, 32'h0, 32'h0, 0, 0,  MTHI, 32'd9, 32'd8, 1, 0, 0, 16'd7);
      applyStimulus(1, 1, DIVU, 32'd100, 32'd7, 0, 0,  32'h0, 32'h0, 32'h0, 0, 0, 0, 16'd7);
      applyStimulus(1, 0, 32'h0, 32'h0, 32'h0, 0, 0,  DIVU, 32'd100, 32'd7, 1, 1, 0, 16'd7);

      // Run the counter up from 7 to 0xFFFE with a held hazard, then check
      // that three more hazard cycles leave it stuck at 0xFFFF.
      for (int i = 0; i < 65527; i++) begin
         driveOnly(1, MFHI, 0, 1);
      end
      applyStimulus(1, 1, MFHI, 32'h0, 32'h0, 0, 1,  32'h0, 32'h0, 32'h0, 0, 0, 1, 16'hFFFE);
      applyStimulus(1, 1, MFHI, 32'h0, 32'h0, 0, 1,  32'h0, 32'h0, 32'h0, 0, 0, 1, 16'hFFFF);
      applyStimulus(1, 1, MFHI, 32'h0, 32'h0, 0, 1,  32'h0, 32'h0, 32'h0, 0, 0, 1, 16'hFFFF);
      applyStimulus(1, 0, 32'h0, 32'h0, 32'h0, 0, 0,  32'h0, 32'h0, 32'h0, 0, 0, 0, 16'hFFFF);

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL drain: got %0d pending required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/md_issue_stage.md
# md_issue_stage

D/E pipeline register and issue controller for the HI/LO multiply-divide path of the five-stage MIPS core. It latches the decoded instruction and its forwarded operands into the E stage. It generates the single-cycle `start` strobe consumed by the E-stage multiply/divide unit. It stalls the D stage while a HI/LO operation is still in flight, and counts those stall cycles.

## Interface
- `CNT_W`, default 16: width of the saturating stall-cycle counter.

- `clk` in 1: core clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset; clears all state immediately while low.
- `d_valid` in 1: D stage holds a real instruction.
- `d_ir` in 32: D-stage instruction word.
- `d_rs_val` in 32: forwarded rs operand for `d_ir`.
- `d_rt_val` in 32: forwarded rt operand for `d_ir`.
- `hz_stall_other` in 1: stall request from the general data-hazard unit.
- `md_busy` in 1: `Busy` from the multiply/divide unit.
- `e_ir` out 32: E-stage instruction word, driven to the multiply/divide unit `IR`.
- `e_srca` out 32: E-stage rs value, driven to `SrcA`.
- `e_srcb` out 32: E-stage rt value, driven to `SrcB`.
- `e_valid` out 1: E stage holds a real instruction.
- `md_start` out 1: one-cycle start strobe for mult/multu/div/divu.
- `d_stall` out 1: freeze PC and the F/D register.
- `md_stall_cnt` out CNT_W: cycles in which the HI/LO hazard term was true.

## Operation
- Instruction classes:
  - Start class: opcode 6'b000000 with funct mult 0x18, multu 0x19, div 0x1A, divu 0x1B.
  - MD class: start class plus mfhi 0x10, mthi 0x11, mflo 0x12, mtlo 0x13.
- `d_md = d_valid & (d_ir in MD class)`.
- `md_pending = md_busy | md_start`. The `md_start` term covers the cycle before Busy rises.
- `md_hazard = d_md & md_pending`.
- `d_stall = hz_stall_other | md_hazard`. This is purely combinational.
- E-register update, every rising edge:
  - If `d_stall`: insert a bubble. `e_ir`=0, `e_srca`=0, `e_srcb`=0, `e_valid`=0, `md_start`=0.
  - Else if `d_valid`=0: insert the same bubble.
  - Else: load `d_ir`, `d_rs_val`, `d_rt_val`; set `e_valid`=1; set `md_start`=1 iff `d_ir` is start class.
- `md_start` is a registered output and is never held for two consecutive cycles. The next edge always reloads it.
- Stall counter: increments by 1 on each edge where `md_hazard`=1. It saturates at all-ones and does not wrap.
- mthi/mtlo/mfhi/mflo never assert `md_start`. They are held in D while `md_pending` is true, so HI/LO is never read or written during a computation.
- Reset (`reset`=0, asynchronous):
  - `e_ir`, `e_srca`, `e_srcb`, `md_stall_cnt` = 0.
  - `e_valid`, `md_start` = 0.
  - `d_stall` follows its inputs, because `md_start`=0 after reset.
- Reset asserted mid-operation drops any E-stage op and any pending strobe. The multiply/divide unit's own Busy is that unit's concern.

## Timing
- Latency from D to E is 1 edge when not stalled.
- A start-class instruction loaded at edge k gives `md_start`=1 for cycle k only.
- Number cycles so a mult is in E in cycle 0. A following MD-class instruction in D:
  - is stalled in cycle 0 by `md_start`;
  - is stalled in cycles 1..N by `md_busy`;
  - is released in the first cycle with `md_busy`=0;
  - is in E one cycle later.
- `hz_stall_other` together with `md_hazard`: a single stall results and the counter still increments.
- `d_valid` low: a bubble and no stall.
- A non-MD instruction behind a mult is never stalled by `md_busy`.

## Test plan
- Reset release, idle inputs:
  - all outputs 0;
  - drop `reset` mid-stream with a mult in E → `md_start`, `e_valid`, `e_ir` go 0 immediately without waiting for a clock.
- Issue mult (`d_ir`=0x00850018, rs=7, rt=-3) with `md_busy`=0 → next cycle:
  - `e_ir`=0x00850018, `e_srca`=7, `e_srcb`=0xFFFFFFFD;
  - `md_start`=1 for exactly one cycle.
- mult in E at cycle 0, `md_busy` high cycles 1-5, mfhi (0x00001010) in D → `d_stall`=1 in cycles 0-5, bubbles in E cycles 1-6, mfhi in E at cycle 7, `md_stall_cnt`=6.
- addu behind a busy mult (`md_busy`=1) → no stall, addu in E next cycle, `md_start`=0, counter unchanged.
- `hz_stall_other`=1 for 2 cycles, D holds a non-MD instruction → `d_stall`=1 for those 2 cycles, 2 bubbles, counter unchanged.
- Force `md_stall_cnt` to 0xFFFE (CNT_W=16), hold `md_hazard` for 3 cycles → counter reads 0xFFFF and stays there.
